// File: rtl/mod_reduce_pkg.sv
// Shared types and elaboration helpers for the sequential modular reducer.
package mod_reduce_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of CHUNK_W-bit chunks covering an IN_W-bit operand.
  function automatic int unsigned f_nchunk(input int unsigned in_w, input int unsigned chunk_w);
    return (in_w + chunk_w - 1) / chunk_w;
  endfunction

  // Residue width; every value < MOD fits.
  function automatic int unsigned f_resw(input int unsigned m);
    return $clog2(m);
  endfunction

  // Legal parameter ranges for the reducer.
  function automatic bit f_params_ok(input int unsigned m, input int unsigned chunk_w);
    return (m >= 2) && (m < (1 << 24)) && (chunk_w >= 1) && (chunk_w <= 8);
  endfunction

endpackage

// File: rtl/mod_shift_reduce.sv
// One Horner step: acc_next = (acc * 2^CHUNK_W + chunk) mod MOD, using CHUNK_W+1
// conditional-subtract stages. Purely combinational.
module mod_shift_reduce
  import mod_reduce_pkg::*;
#(
  parameter int unsigned MOD     = 4051,
  parameter int unsigned CHUNK_W = 6
) (
  input  logic [$clog2(MOD)-1:0] acc,
  input  logic [CHUNK_W-1:0]     chunk,
  output logic [$clog2(MOD)-1:0] acc_next
);

  localparam int unsigned RES_W = f_resw(MOD);
  // acc < MOD so t < MOD * 2^(CHUNK_W+1); this width never truncates.
  localparam int unsigned TW = RES_W + CHUNK_W + 1;
  localparam logic [TW-1:0] MOD_T = TW'(MOD);

  logic [TW-1:0] t;

  // Subtract MOD<<k from the largest k down; each stage leaves t < MOD<<k.
  always_comb begin
    t = TW'({acc, chunk});
    for (int k = CHUNK_W; k >= 0; k--) begin
      if (t >= (MOD_T << k)) begin
        t = t - (MOD_T << k);
      end
    end
    acc_next = t[RES_W-1:0];
  end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential residue generator: in_data mod MOD, one CHUNK_W-bit chunk per clock,
// most significant chunk first, valid/ready on both sides.
// Optional feature: define MODRED_ZSKIP_EN to skip leading all-zero chunks on accept.
module mod_reduce_seq
  import mod_reduce_pkg::*;
#(
  parameter int unsigned IN_W    = 500,
  parameter int unsigned MOD     = 4051,
  parameter int unsigned CHUNK_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(MOD)-1:0] out_res
);

  localparam int unsigned RES_W  = f_resw(MOD);
  localparam int unsigned NCHUNK = f_nchunk(IN_W, CHUNK_W);
  localparam int unsigned PAD_W  = NCHUNK * CHUNK_W;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  if (!f_params_ok(MOD, CHUNK_W)) begin : g_param_check
    $error("mod_reduce_seq: need 2 <= MOD < 2^24 and 1 <= CHUNK_W <= 8");
  end

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   sreg_q, sreg_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RES_W-1:0]   acc_step;
  logic [PAD_W-1:0]   load_sreg;
  logic [CNT_W-1:0]   load_count;
  logic               accept;

  mod_shift_reduce #(
    .MOD     (MOD),
    .CHUNK_W (CHUNK_W)
  ) u_step (
    .acc      (acc_q),
    .chunk    (sreg_q[PAD_W-1 -: CHUNK_W]),
    .acc_next (acc_step)
  );

`ifdef MODRED_ZSKIP_EN
  logic [PAD_W-1:0] padded;
  logic [CNT_W-1:0] nz;

  // nz = index+1 of the highest nonzero chunk; shift it up to the top of the register.
  always_comb begin
    padded = PAD_W'(in_data);
    nz     = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (|padded[i*CHUNK_W +: CHUNK_W]) begin
        nz = CNT_W'(i + 1);
      end
    end
    load_count = nz;
    load_sreg  = padded << ((NCHUNK - 32'(nz)) * CHUNK_W);
  end
`else
  // Fixed-latency load: zero-padded operand, full chunk count.
  always_comb begin
    load_sreg  = PAD_W'(in_data);
    load_count = CNT_W'(NCHUNK);
  end
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      StRun: begin
        acc_d   = acc_step;
        sreg_d  = sreg_q << CHUNK_W;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = StDone;
          res_d   = acc_step;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        // A new operand may enter on the same edge the result leaves.
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = StIdle;
          accept  = in_valid;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      sreg_d  = load_sreg;
      acc_d   = '0;
      count_d = load_count;
      if (load_count == '0) begin
        // Only reachable with zero-skip: all-zero operand is done immediately.
        state_d = StDone;
        res_d   = '0;
      end else begin
        state_d = StRun;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      res_q   <= res_d;
    end
  end

  assign out_res = res_q;

endmodule
